// File: rtl/stepper_phase_seq_pkg.sv
// Shared types and helpers for the N-phase stepper sequencer.
// The phase pattern is returned 8 bits wide so one function serves every PHASES value (3..8).
package stepper_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_DOUBLE = 2'd1;
  localparam logic [1:0] MODE_HALF   = 2'd2;

  // Even index 2k energises phase k; odd index 2k+1 energises k and (k+1) mod phases.
  function automatic logic [7:0] phase_pattern(input logic [3:0] idx, input logic [3:0] phases);
    logic [3:0] k;
    logic [3:0] k_next;
    logic [7:0] pat;
    k      = {1'b0, idx[3:1]};
    k_next = ((k + 4'd1) == phases) ? 4'd0 : (k + 4'd1);
    pat    = 8'd1 << k;
    if (idx[0]) begin
      pat = pat | (8'd1 << k_next);
    end else begin
      pat = pat;
    end
    return pat;
  endfunction

endpackage

// File: rtl/stepper_phase_seq_prescaler.sv
// Step-rate prescaler: emits one tick every div+1 enabled cycles.
// A count left above a newly lowered divide value wraps to zero without ticking.
module step_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             clr_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Prescaler count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare, wrap and tick generation
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == div_i) begin
        tick_o = 1'b1;
        cnt_d  = '0;
      end else if (cnt_q > div_i) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

endmodule

// File: rtl/stepper_phase_seq.sv
// N-phase stepper phase sequencer: single/two-phase/half-step drive, counted or continuous moves.
// All outputs come straight from registers; busy is the decoded state register.
module stepper_phase_seq
  import stepper_pkg::*;
#(
  parameter int PHASES = 3,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 16,
  parameter bit HOLD   = 1'b1
) (
  input  logic              CP,
  input  logic              nCR,
  input  logic              en,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [CNT_W-1:0]  steps,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              step_pulse,
  output logic [3:0]        pos,
  output logic [PHASES-1:0] phase_out
);

  localparam logic [4:0] N2 = 5'(2 * PHASES);

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              energised_q, energised_d;
  logic              done_q, done_d;
  logic              pulse_q, pulse_d;
  logic [PHASES-1:0] phase_q, phase_d;

  logic       tick_s, run_tick_s, accept_s, last_s;
  logic [4:0] stride_s, sum_s;
  logic [3:0] adv_s;

  step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (CP),
    .rst_n  (nCR),
    .en_i   (en && (state_q == RUN)),
    .div_i  (div),
    .clr_i  (state_q == IDLE),
    .tick_o (tick_s)
  );

  assign accept_s   = (state_q == IDLE) && start && !stop;
  assign run_tick_s = (state_q == RUN) && tick_s && !stop;
  assign last_s     = (rem_q == {{(CNT_W-1){1'b0}}, 1'b1});

  // State register
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop outranks a same-cycle tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = RUN;
        else          state_d = IDLE;
      end
      RUN: begin
        if (stop)                     state_d = IDLE;
        else if (run_tick_s && last_s) state_d = IDLE;
        else                          state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Index advance: stride chosen so single/two-phase land on the right parity
  always_comb begin
    stride_s = 5'd1;
    case (mode)
      MODE_SINGLE: stride_s = idx_q[0] ? 5'd1 : 5'd2;
      MODE_DOUBLE: stride_s = idx_q[0] ? 5'd2 : 5'd1;
      default:     stride_s = 5'd1;
    endcase
    if (dir) begin
      sum_s = {1'b0, idx_q} + stride_s;
      if (sum_s >= N2) sum_s = sum_s - N2;
      else             sum_s = sum_s;
    end else begin
      if ({1'b0, idx_q} >= stride_s) sum_s = {1'b0, idx_q} - stride_s;
      else                           sum_s = {1'b0, idx_q} + N2 - stride_s;
    end
    adv_s = 4'(sum_s);
  end

  // Datapath and registered-output next values
  always_comb begin
    idx_d       = idx_q;
    rem_d       = rem_q;
    energised_d = energised_q;
    done_d      = 1'b0;
    pulse_d     = 1'b0;
    if ({1'b0, idx_q} >= N2) begin
      idx_d = 4'd0;
    end else if (run_tick_s) begin
      idx_d = adv_s;
    end else begin
      idx_d = idx_q;
    end
    if (accept_s) begin
      rem_d       = steps;
      energised_d = 1'b1;
    end else if (run_tick_s && (rem_q != '0)) begin
      rem_d = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      rem_d = rem_q;
    end
    if (run_tick_s) begin
      pulse_d = 1'b1;
      done_d  = last_s;
    end else begin
      pulse_d = 1'b0;
      done_d  = 1'b0;
    end
    if (energised_d && (HOLD || (state_d == RUN))) begin
      phase_d = PHASES'(phase_pattern(idx_d, 4'(PHASES)));
    end else begin
      phase_d = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      idx_q       <= 4'd0;
      rem_q       <= '0;
      energised_q <= 1'b0;
      done_q      <= 1'b0;
      pulse_q     <= 1'b0;
      phase_q     <= '0;
    end else begin
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      energised_q <= energised_d;
      done_q      <= done_d;
      pulse_q     <= pulse_d;
      phase_q     <= phase_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign step_pulse = pulse_q;
  assign pos        = idx_q;
  assign phase_out  = phase_q;

endmodule
